mux_nway_reg: RTL and testbench
===============================

# mux_nway_reg

Registered, parametrised N-channel multiplexer with a valid/ready handshake on every input and on the output. It picks one input per transfer, either from an explicit select (static mode) or by fair round-robin among the requesting inputs, and holds the result in a one-deep output register. Operand and partial-product steering in the multiplier datapath uses it wherever a source must be chosen under back-pressure instead of purely combinationally.

## Interface
- WIDTH, 2: bits per channel.
- CHANNELS, 4: number of inputs; must be at least 2.
- SEL_W, $clog2(CHANNELS): select and channel-index width (derived, not overridden).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel request.
- in_ready  out  CHANNELS  per-channel accept; one-hot or zero.
- mode  in  1  0 = static select, 1 = round-robin.
- sel  in  SEL_W  channel index used in static mode.
- out_data  out  WIDTH  registered selected data.
- out_chan  out  SEL_W  index of the channel held in out_data.
- out_valid  out  1  output register full.
- out_ready  in  1  downstream accept.

## Operation
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_load = ~out_valid | out_ready.
- Static mode: grant = sel when sel < CHANNELS and in_valid[sel]=1; otherwise no grant. An out-of-range sel never grants and never asserts in_ready.
- Round-robin mode: search starts at rr_ptr+1 and wraps modulo CHANNELS; the first channel with in_valid=1 wins. rr_ptr moves to the winner only on a transfer.
- in_ready[g] = can_load for the granted channel g. All other bits are 0. in_ready depends combinationally on in_valid, mode and sel.
- Transfer on channel g: in_valid[g] & in_ready[g]. On the next edge, out_data takes data g, out_chan takes g, and out_valid becomes 1.
- Output drain: out_valid & out_ready with no new transfer moves the state FULL→EMPTY. When drain and load happen together, the register stays FULL with the new data, giving full throughput.
- While FULL with out_ready=0, out_data and out_chan stay stable.
- Changes to mode or sel affect only the next grant. Held output data is never altered.
- Static-mode transfers do not move rr_ptr.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 transfer per cycle while out_ready=1.
- Reset values: out_valid=0, out_data=0, out_chan=0, rr_ptr=CHANNELS-1 (so the first round-robin search starts at channel 0). in_ready is all 0 during reset.
- Reset mid-transfer: held data is discarded and no in_ready is asserted in the reset cycle.
- When all in_valid are 0, in_ready is all 0 and a FULL register drains normally.

## Configuration
- MUX_NWAY_RR_EN defined: round-robin logic and rr_ptr are built, and mode is honoured.
- MUX_NWAY_RR_EN undefined: the mode input is ignored, the block always runs static, no rr_ptr exists, and the rest of the behaviour is identical.

## Structure
- Package mux_pkg:
  - MODE_STATIC=1'b0, MODE_RR=1'b1.
  - Clog2 helper, used only if the tool lacks $clog2.
- Sub-module rr_arbiter: CHANNELS-wide request vector and pointer in, one-hot grant and encoded index out. Instantiated only under MUX_NWAY_RR_EN.

## Test plan
All scenarios use WIDTH=2, CHANNELS=4.
- Reset, then static, sel=2, in_data={11,10,01,00}, in_valid=0100, out_ready=1: in_ready=0100, and next cycle out_data=10, out_chan=2, out_valid=1.
- Static, sel=1, in_valid[1]=1, out_ready=0 for 3 cycles: one transfer only, after which in_ready=0000 and out_data stays stable. Raise out_ready: the next item is accepted in the same cycle the first drains.
- Round-robin, in_valid=1111 held, out_ready=1: out_chan sequence is 0,1,2,3,0, one per cycle.
- Round-robin, in_valid=1010, rr_ptr=1 after a grant to channel 1: next grant is 3, then 1.
- Static, sel=3, in_valid=0111: in_ready=0000 and out_valid stays 0.
- Round-robin mid-stream, assert rst_n=0 for one cycle: out_valid=0, out_data=00, and the next grant with in_valid=1111 is channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg
// Shared definitions for the registered N-way multiplexer slice:
//   - mode encodings for the 'mode' input (static select vs round-robin)
//   - state encoding of the one-deep output register
//   - clog2 helper for tools without a usable $clog2
package mux_pkg;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // The output register is either holding nothing or holding one item.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Ceiling log2. Kept as a fallback for flows whose elaborator lacks $clog2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Fair round-robin arbiter. The search starts one past the last winner and
// wraps modulo CHANNELS, so the most recent winner has the lowest priority.
// Purely combinational; the caller owns and updates the pointer.
// Ports:
//   req   in  CHANNELS  request vector
//   ptr   in  SEL_W     index of the last winner
//   grant out CHANNELS  one-hot grant, zero when nothing requests
//   idx   out SEL_W     encoded index of the granted channel (0 when none)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    idx
);

  // Walk the channels starting at ptr+1; the first requester wins. The
  // offset k runs to CHANNELS so that ptr itself is considered last.
  always_comb begin
    logic found;
    int   c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      c = (int'(ptr) + k) % CHANNELS;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/mux_nway_reg.sv
// mux_nway_reg
// Registered N-channel multiplexer with valid/ready on every input and on the
// output. One input is chosen per transfer, either by an explicit select
// (static mode) or by round-robin among requesters, and the chosen item is
// held in a one-deep output register that supports full throughput.
//
// Build option: define MUX_NWAY_RR_EN to build the round-robin arbiter and
// rr_ptr and to honour 'mode'. Without it 'mode' is ignored and the block is
// always static.
//
// Ports:
//   clk        in  1                rising-edge clock
//   rst_n      in  1                synchronous active-low reset
//   in_data    in  CHANNELS*WIDTH   channel i at [i*WIDTH +: WIDTH]
//   in_valid   in  CHANNELS         per-channel request
//   in_ready   out CHANNELS         per-channel accept, one-hot or zero
//   mode       in  1                MODE_STATIC / MODE_RR
//   sel        in  SEL_W            channel used in static mode
//   out_data   out WIDTH            held data
//   out_chan   out SEL_W            channel the held data came from
//   out_valid  out 1                output register full
//   out_ready  in  1                downstream accept
module mux_nway_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  out_state_t          state;
  logic [CHANNELS-1:0] static_oh;
  logic [SEL_W-1:0]    static_idx;
  logic [CHANNELS-1:0] grant_oh;
  logic [SEL_W-1:0]    grant_idx;
  logic [WIDTH-1:0]    grant_data;
  logic                can_load;
  logic                xfer;

  // Static grant: matching sel against every legal index means an
  // out-of-range sel (non power-of-two CHANNELS) simply matches nothing.
  always_comb begin
    static_oh  = '0;
    static_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) begin
        static_oh[i] = 1'b1;
        static_idx   = SEL_W'(i);
      end
    end
  end

`ifdef MUX_NWAY_RR_EN
  logic [SEL_W-1:0]    rr_ptr;
  logic [CHANNELS-1:0] rr_oh;
  logic [SEL_W-1:0]    rr_idx;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (rr_oh),
    .idx   (rr_idx)
  );

  always_comb begin
    grant_oh  = static_oh;
    grant_idx = static_idx;
    if (mode == MODE_RR) begin
      grant_oh  = rr_oh;
      grant_idx = rr_idx;
    end
  end

  // The pointer only follows round-robin transfers, so static traffic
  // does not disturb fairness. Reset value makes the first search start at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= SEL_W'(CHANNELS - 1);
    end else if (xfer && mode == MODE_RR) begin
      rr_ptr <= rr_idx;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign grant_oh    = static_oh;
  assign grant_idx   = static_idx;
`endif

  // Pick the granted channel's data; zero when nothing is granted.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_oh[i]) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Accept when the register is empty or is being drained this cycle.
  // Nothing is accepted while reset is asserted.
  assign can_load  = (state == ST_EMPTY) || out_ready;
  assign in_ready  = (rst_n && can_load) ? grant_oh : '0;
  assign xfer      = |in_ready;
  assign out_valid = (state == ST_FULL);

  // Output register. A load wins over a drain, which keeps the register
  // full on simultaneous drain+load and gives one transfer per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_chan <= '0;
    end else if (xfer) begin
      state    <= ST_FULL;
      out_data <= grant_data;
      out_chan <= grant_idx;
    end else if (out_ready) begin
      state    <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_nway_reg.sv
// tb_mux_nway_reg
// Scoreboard bench for mux_nway_reg (WIDTH=2, CHANNELS=4). The stimulus task
// predicts grants from a behavioural model and queues the expected output
// item; a separate negedge monitor compares whatever the DUT holds against
// the front of the queue and pops it on each output handshake.
module tb_mux_nway_reg;

  localparam int WIDTH    = 2;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

`ifdef MUX_NWAY_RR_EN
  localparam bit RR_BUILT = 1'b1;
`else
  localparam bit RR_BUILT = 1'b0;
`endif

  logic                      clk       = 1'b0;
  logic                      rst_n     = 1'b0;
  logic [CHANNELS*WIDTH-1:0] in_data   = '0;
  logic [CHANNELS-1:0]       in_valid  = '0;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode      = 1'b0;
  logic [SEL_W-1:0]          sel       = '0;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready = 1'b0;

  typedef struct {
    int data;
    int chan;
  } item_t;

  item_t sb[$];
  item_t pending;
  bit    have_pending = 1'b0;
  bit    reset_seen   = 1'b1;
  int    model_ptr    = CHANNELS - 1;
  int    n_checks     = 0;
  int    n_fail       = 0;

  mux_nway_reg #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference choice of channel: static picks sel if it is requesting,
  // round-robin picks the first requester after the last round-robin winner.
  function automatic int modelGrant(input logic [3:0] v, input logic m, input logic [1:0] s);
    if (!(RR_BUILT && m)) begin
      if (int'(s) < CHANNELS && v[s]) return int'(s);
      return -1;
    end
    for (int k = 1; k <= CHANNELS; k++) begin
      int c;
      c = (model_ptr + k) % CHANNELS;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: settle the previous cycle's bookkeeping, drive new
  // inputs, predict in_ready and any transfer.
  task automatic applyStimulus(input logic [3:0] v, input logic [7:0] d, input logic m,
                               input logic [1:0] s, input logic r, input logic rn);
    int         g;
    logic [3:0] exp_ready;
    @(posedge clk);
    #1;
    if (reset_seen) begin
      sb.delete();
      model_ptr = CHANNELS - 1;
      reset_seen = 1'b0;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_out_chan", 32'(out_chan), 32'd0);
    end
    if (have_pending) begin
      sb.push_back(pending);
      have_pending = 1'b0;
    end
    in_valid  = v;
    in_data   = d;
    mode      = m;
    sel       = s;
    out_ready = r;
    rst_n     = rn;
    #1;
    exp_ready = '0;
    if (rn) begin
      g = modelGrant(v, m, s);
      if (g >= 0 && (sb.size() == 0 || r)) begin
        exp_ready[g]  = 1'b1;
        pending.data  = int'((d >> (g * WIDTH)) & 8'h3);
        pending.chan  = g;
        have_pending  = 1'b1;
        if (RR_BUILT && m) model_ptr = g;
      end
    end else begin
      reset_seen = 1'b1;
    end
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
  endtask

  // Monitor: the queue mirrors exactly what the output register should hold.
  always @(negedge clk) begin
    checkOutput("out_valid", 32'(out_valid), (sb.size() != 0) ? 32'd1 : 32'd0);
    if (out_valid === 1'b1 && sb.size() != 0) begin
      checkOutput("out_data", 32'(out_data), 32'(sb[0].data));
      checkOutput("out_chan", 32'(out_chan), 32'(sb[0].chan));
      if (out_ready === 1'b1) void'(sb.pop_front());
    end
  end

  initial begin
    // reset
    applyStimulus(4'b0000, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);

    // static sel=2, channel data {11,10,01,00}
    applyStimulus(4'b0100, 8'b11_10_01_00, 1'b0, 2'd2, 1'b1, 1'b1);
    applyStimulus(4'b0000, 8'b11_10_01_00, 1'b0, 2'd2, 1'b1, 1'b1);

    // static sel=1 under back-pressure, then release
    applyStimulus(4'b0010, 8'b00_00_11_00, 1'b0, 2'd1, 1'b0, 1'b1);
    applyStimulus(4'b0010, 8'b00_00_01_00, 1'b0, 2'd1, 1'b0, 1'b1);
    applyStimulus(4'b0010, 8'b00_00_10_00, 1'b0, 2'd1, 1'b0, 1'b1);
    applyStimulus(4'b0010, 8'b00_00_01_00, 1'b0, 2'd1, 1'b1, 1'b1);
    applyStimulus(4'b0000, 8'h00, 1'b0, 2'd1, 1'b1, 1'b1);
    applyStimulus(4'b0000, 8'h00, 1'b0, 2'd1, 1'b1, 1'b1);

    // round-robin, all requesting
    for (int i = 0; i < 5; i++)
      applyStimulus(4'b1111, 8'b11_10_01_00, 1'b1, 2'd0, 1'b1, 1'b1);

    // round-robin, pointer parked at 1, then 1010
    applyStimulus(4'b0010, 8'b01_10_11_00, 1'b1, 2'd0, 1'b1, 1'b1);
    applyStimulus(4'b1010, 8'b01_10_11_00, 1'b1, 2'd0, 1'b1, 1'b1);
    applyStimulus(4'b1010, 8'b01_10_11_00, 1'b1, 2'd0, 1'b1, 1'b1);

    // static sel=3 with channel 3 idle
    applyStimulus(4'b0111, 8'hE4, 1'b0, 2'd3, 1'b1, 1'b1);
    applyStimulus(4'b0111, 8'hE4, 1'b0, 2'd3, 1'b1, 1'b1);
    applyStimulus(4'b0111, 8'hE4, 1'b0, 2'd3, 1'b1, 1'b1);

    // round-robin mid-stream reset
    applyStimulus(4'b1111, 8'hE4, 1'b1, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b1111, 8'hE4, 1'b1, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b1111, 8'hE4, 1'b1, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b1111, 8'hE4, 1'b1, 2'd0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 8'hE4, 1'b1, 2'd0, 1'b1, 1'b1);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      applyStimulus(4'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
                    ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
    end

    // drain
    for (int i = 0; i < 4; i++)
      applyStimulus(4'b0000, 8'h00, 1'b0, 2'd0, 1'b1, 1'b1);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
